// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequentially scans a voice table and issues one gate update per note event.
// Optional build macro VOICE_STEAL_EN: round-robin voice stealing when the table is full.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_note_valid,
    output logic        o_note_ready,
    input  logic        i_note_on,
    input  logic [6:0]  i_note_num,
    input  logic [6:0]  i_velocity,
    input  logic [31:0] i_tuning_code,
    output logic        o_SPI_flag,
    output logic        o_SPI_note_status,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_dropped,
    output logic [8:0]  o_active_count
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    state_t state;
    state_t next_state;

    logic                  ev_on;
    logic [6:0]            ev_note;
    logic [6:0]            ev_vel;
    logic [31:0]           ev_tune;

    logic [NUM_VOICES-1:0] slot_active;
    logic [6:0]            slot_note [NUM_VOICES];
    logic [31:0]           slot_tune [NUM_VOICES];

    logic [IDX_W-1:0]      scan_idx;
    logic                  match_found;
    logic [IDX_W-1:0]      match_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      target_idx;
    logic                  tgt_new;

    logic                  accept_c;
    logic                  scan_last_c;
    logic                  hit_c;
    logic                  match_found_c;
    logic [IDX_W-1:0]      match_idx_c;
    logic                  free_found_c;
    logic [IDX_W-1:0]      free_idx_c;
    logic                  target_ok_c;
    logic [IDX_W-1:0]      target_c;
    logic                  new_c;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]      steal_ptr;
    logic                  tgt_steal;
    logic                  steal_c;
`endif

    assign accept_c    = (state == IDLE) && i_note_valid && o_note_ready;
    assign scan_last_c = (state == SCAN) && (scan_idx == LAST_IDX);

    // Fold the slot under examination into the running search results and pick a target.
    always_comb begin
        hit_c         = slot_active[scan_idx] && (slot_note[scan_idx] == ev_note);
        match_found_c = match_found || hit_c;
        match_idx_c   = match_found ? match_idx : scan_idx;
        free_found_c  = free_found || !slot_active[scan_idx];
        free_idx_c    = free_found ? free_idx : scan_idx;
        target_ok_c   = 1'b0;
        target_c      = '0;
        new_c         = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_c       = 1'b0;
`endif
        if (match_found_c) begin
            target_ok_c = 1'b1;
            target_c    = match_idx_c;
        end else if (ev_on && free_found_c) begin
            target_ok_c = 1'b1;
            target_c    = free_idx_c;
            new_c       = 1'b1;
        end
`ifdef VOICE_STEAL_EN
        else if (ev_on) begin
            target_ok_c = 1'b1;
            target_c    = steal_ptr;
            steal_c     = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = SCAN;
            SCAN:    if (scan_last_c) next_state = target_ok_c ? ISSUE : IDLE;
            ISSUE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready only after a full cycle resting in IDLE, so it is never high outside IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_note_ready <= 1'b0;
        else            o_note_ready <= (state == IDLE) && (next_state == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ev_on             <= 1'b0;
            ev_note           <= '0;
            ev_vel            <= '0;
            ev_tune           <= '0;
            scan_idx          <= '0;
            match_found       <= 1'b0;
            match_idx         <= '0;
            free_found        <= 1'b0;
            free_idx          <= '0;
            target_idx        <= '0;
            tgt_new           <= 1'b0;
            slot_active       <= '0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                slot_note[i] <= '0;
                slot_tune[i] <= '0;
            end
            o_SPI_flag        <= 1'b0;
            o_SPI_note_status <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_SPI_velocity    <= '0;
            o_dropped         <= 1'b0;
            o_active_count    <= '0;
`ifdef VOICE_STEAL_EN
            steal_ptr         <= '0;
            tgt_steal         <= 1'b0;
`endif
        end else begin
            o_SPI_flag <= 1'b0;
            o_dropped  <= 1'b0;
            if (accept_c) begin
                ev_on       <= i_note_on && (i_velocity != 7'd0);
                ev_note     <= i_note_num;
                ev_vel      <= i_velocity;
                ev_tune     <= i_tuning_code;
                scan_idx    <= '0;
                match_found <= 1'b0;
                free_found  <= 1'b0;
            end
            if (state == SCAN) begin
                scan_idx    <= scan_idx + IDX_W'(1);
                match_found <= match_found_c;
                match_idx   <= match_idx_c;
                free_found  <= free_found_c;
                free_idx    <= free_idx_c;
                if (scan_last_c) begin
                    target_idx <= target_c;
                    tgt_new    <= new_c;
                    o_dropped  <= !target_ok_c;
`ifdef VOICE_STEAL_EN
                    tgt_steal  <= steal_c;
`endif
                end
            end
            // Commit the update to the table and present it to the voice controller.
            if (state == ISSUE) begin
                o_SPI_flag        <= 1'b1;
                o_SPI_note_status <= ev_on;
                o_SPI_voice_index <= 8'(target_idx);
                if (ev_on) begin
                    o_SPI_tuning_code     <= ev_tune;
                    o_SPI_velocity        <= ev_vel;
                    slot_active[target_idx] <= 1'b1;
                    slot_note[target_idx] <= ev_note;
                    slot_tune[target_idx] <= ev_tune;
                    if (tgt_new) o_active_count <= o_active_count + 9'd1;
`ifdef VOICE_STEAL_EN
                    if (tgt_steal) steal_ptr <= steal_ptr + IDX_W'(1);
`endif
                end else begin
                    o_SPI_tuning_code     <= slot_tune[target_idx];
                    o_SPI_velocity        <= '0;
                    slot_active[target_idx] <= 1'b0;
                    o_active_count        <= o_active_count - 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (NUM_VOICES=16); honours VOICE_STEAL_EN when defined.
module tb_voice_allocator;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_note_valid = 1'b0;
    logic        o_note_ready;
    logic        i_note_on = 1'b0;
    logic [6:0]  i_note_num = '0;
    logic [6:0]  i_velocity = '0;
    logic [31:0] i_tuning_code = '0;
    logic        o_SPI_flag;
    logic        o_SPI_note_status;
    logic [7:0]  o_SPI_voice_index;
    logic [31:0] o_SPI_tuning_code;
    logic [6:0]  o_SPI_velocity;
    logic        o_dropped;
    logic [8:0]  o_active_count;

    voice_allocator #(.NUM_VOICES(16)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_note_valid      (i_note_valid),
        .o_note_ready      (o_note_ready),
        .i_note_on         (i_note_on),
        .i_note_num        (i_note_num),
        .i_velocity        (i_velocity),
        .i_tuning_code     (i_tuning_code),
        .o_SPI_flag        (o_SPI_flag),
        .o_SPI_note_status (o_SPI_note_status),
        .o_SPI_voice_index (o_SPI_voice_index),
        .o_SPI_tuning_code (o_SPI_tuning_code),
        .o_SPI_velocity    (o_SPI_velocity),
        .o_dropped         (o_dropped),
        .o_active_count    (o_active_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          issue;
        logic [7:0]  idx;
        logic        st;
        logic [31:0] tune;
        logic [6:0]  vel;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge i_clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every flag or drop pulse is matched against the oldest expectation.
    always @(negedge i_clk) begin
        if (i_reset_n && (o_SPI_flag || o_dropped)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, o_SPI_flag, o_dropped}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind", {30'd0, o_SPI_flag, o_dropped}, e.issue ? 32'd2 : 32'd1);
                chk("event_cycle", 32'(cycle), 32'(e.cyc));
                chk("active_count", 32'(o_active_count), 32'(e.cnt));
                if (e.issue && o_SPI_flag) begin
                    chk("voice_index", 32'(o_SPI_voice_index), 32'(e.idx));
                    chk("note_status", 32'(o_SPI_note_status), 32'(e.st));
                    chk("tuning_code", o_SPI_tuning_code, e.tune);
                    chk("velocity", 32'(o_SPI_velocity), 32'(e.vel));
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int w = 0;
        while (!o_note_ready && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_note_ready) chk(name, 32'(o_note_ready), 32'd1);
    endtask

    // Issue one event, then scramble inputs (and optionally keep valid high) while busy.
    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v, input logic [31:0] t,
                        input bit issue, input logic [7:0] idx, input logic st,
                        input logic [31:0] etune, input logic [6:0] evel, input int cnt, input bit poke);
        exp_t e;
        @(negedge i_clk);
        wait_ready("ready_timeout_pre");
        i_note_on     = on;
        i_note_num    = n;
        i_velocity    = v;
        i_tuning_code = t;
        i_note_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        e.issue = issue; e.idx = idx; e.st = st; e.tune = etune; e.vel = evel; e.cnt = cnt;
        e.cyc   = cycle + (issue ? 17 : 16);
        exp_q.push_back(e);
        i_note_on     = ~on;
        i_note_num    = n ^ 7'h55;
        i_velocity    = ~v;
        i_tuning_code = ~t;
        i_note_valid  = poke;
        repeat (8) @(negedge i_clk);
        i_note_valid  = 1'b0;
        wait_ready("ready_timeout_post");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_note_ready), 32'd0);
        chk({tag, "_flag"}, 32'(o_SPI_flag), 32'd0);
        chk({tag, "_status"}, 32'(o_SPI_note_status), 32'd0);
        chk({tag, "_index"}, 32'(o_SPI_voice_index), 32'd0);
        chk({tag, "_tuning"}, o_SPI_tuning_code, 32'd0);
        chk({tag, "_velocity"}, 32'(o_SPI_velocity), 32'd0);
        chk({tag, "_dropped"}, 32'(o_dropped), 32'd0);
        chk({tag, "_count"}, 32'(o_active_count), 32'd0);
    endtask

    initial begin
        #1 i_reset_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1 chk("ready_after_reset", 32'(o_note_ready), 32'd1);

        send(1, 7'd60, 7'd100, 32'h0001_0000, 1, 8'd0, 1, 32'h0001_0000, 7'd100, 1, 0);
        send(1, 7'd64, 7'd80,  32'h0001_4000, 1, 8'd1, 1, 32'h0001_4000, 7'd80,  2, 1);
        send(0, 7'd60, 7'd33,  32'hDEAD_BEEF, 1, 8'd0, 0, 32'h0001_0000, 7'd0,   1, 0);
        send(1, 7'd60, 7'd50,  32'h0001_0000, 1, 8'd0, 1, 32'h0001_0000, 7'd50,  2, 0);
        send(1, 7'd60, 7'd70,  32'h0001_0001, 1, 8'd0, 1, 32'h0001_0001, 7'd70,  2, 1);
        send(0, 7'd72, 7'd40,  32'h0000_1111, 0, 8'd0, 0, 32'h0,         7'd0,   2, 0);
        send(1, 7'd72, 7'd0,   32'h0000_2222, 0, 8'd0, 0, 32'h0,         7'd0,   2, 0);

        for (int k = 0; k < 14; k++) begin
            logic [6:0] n;
            n = 7'(20 + k);
            send(1, n, n, 32'h0002_0000 + 32'(n), 1, 8'(2 + k), 1, 32'h0002_0000 + 32'(n), n, 3 + k, 0);
        end

`ifdef VOICE_STEAL_EN
        send(1, 7'd90, 7'd90, 32'h0003_0000, 1, 8'd0, 1, 32'h0003_0000, 7'd90, 16, 0);
        send(1, 7'd91, 7'd91, 32'h0003_0001, 1, 8'd1, 1, 32'h0003_0001, 7'd91, 16, 0);
`else
        send(1, 7'd90, 7'd90, 32'h0003_0000, 0, 8'd0, 0, 32'h0, 7'd0, 16, 0);
        send(1, 7'd91, 7'd91, 32'h0003_0001, 0, 8'd0, 0, 32'h0, 7'd0, 16, 0);
`endif
        send(0, 7'd25, 7'd1, 32'h0, 1, 8'd7, 0, 32'h0002_0019, 7'd0, 15, 0);

        // Abort an event with reset in the middle of its scan.
        @(negedge i_clk);
        wait_ready("ready_timeout_abort");
        i_note_on = 1'b1; i_note_num = 7'd100; i_velocity = 7'd9; i_tuning_code = 32'h0004_0000;
        i_note_valid = 1'b1;
        @(posedge i_clk);
        #1 i_note_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (20) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1 chk("ready_after_abort", 32'(o_note_ready), 32'd1);

        send(1, 7'd61, 7'd10, 32'h0000_1234, 1, 8'd0, 1, 32'h0000_1234, 7'd10, 1, 0);
        send(0, 7'd25, 7'd5,  32'h0,         0, 8'd0, 0, 32'h0,         7'd0,  1, 0);
        send(0, 7'd61, 7'd5,  32'h0,         1, 8'd0, 0, 32'h0000_1234, 7'd0,  0, 0);

        repeat (30) @(negedge i_clk);
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 16, number of voice slots managed; power of two, 2..256.
REQ-002 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_note_valid  input  1  note event present; held by upstream until accepted.
REQ-005 o_note_ready  output  1  allocator idle and able to accept; event accepted on edge with i_note_valid=1 and o_note_ready=1.
REQ-006 i_note_on  input  1  1 = note-on, 0 = note-off.
REQ-007 i_note_num  input  7  MIDI note number.
REQ-008 i_velocity  input  7  MIDI velocity.
REQ-009 i_tuning_code  input  32  DDS phase increment for i_note_num.
REQ-010 o_SPI_flag  output  1  one-cycle update strobe to the voice controller.
REQ-011 o_SPI_note_status  output  1  1 = gate on, 0 = gate off for addressed voice.
REQ-012 o_SPI_voice_index  output  8  addressed voice slot, zero-extended.
REQ-013 o_SPI_tuning_code  output  32  tuning code for addressed voice.
REQ-014 o_SPI_velocity  output  7  velocity for addressed voice.
REQ-015 o_dropped  output  1  one-cycle pulse: event discarded.
REQ-016 o_active_count  output  9  number of voices currently gated on.

Function
REQ-017 The block SHALL hold a per-voice table: active bit, 7-bit note, 32-bit tuning code.
REQ-018 The FSM SHALL have states IDLE, SCAN, ISSUE; o_note_ready SHALL be a register equal to 1 only in IDLE.
REQ-019 IDLE -> SCAN on accept; event fields SHALL be latched at the accepting edge; later input changes SHALL be ignored.
REQ-020 A note-on with velocity 0 SHALL be treated as a note-off.
REQ-021 SCAN SHALL examine one slot per cycle, index 0 to NUM_VOICES-1, for exactly NUM_VOICES cycles regardless of match.
REQ-022 Note-on target priority: lowest-index active slot with same note (retrigger); else lowest-index inactive slot; else steal (REQ-037).
REQ-023 Note-off target: lowest-index active slot with same note; if none, o_dropped SHALL pulse in the cycle after scan end, no o_SPI_flag, return to IDLE.
REQ-024 SCAN -> ISSUE after the last slot if a target exists; ISSUE lasts one cycle, then IDLE.
REQ-025 o_SPI_flag SHALL be high for exactly one cycle, NUM_VOICES+1 rising edges after the accepting edge; o_note_ready SHALL return to 1 on the following edge.
REQ-026 On note-on issue: status=1, index=target, tuning=latched code, velocity=latched velocity; slot written active with note and tuning.
REQ-027 On note-off issue: status=0, index=target, tuning=slot's stored code, velocity=0; slot active bit cleared.
REQ-028 All o_SPI_* data outputs SHALL change only on the edge that raises o_SPI_flag and hold until the next issue.
REQ-029 o_active_count SHALL increment on note-on into an inactive slot, decrement on note-off issue, and be unchanged on retrigger or steal; range 0..NUM_VOICES.
REQ-030 i_note_valid while o_note_ready=0 SHALL have no effect.

Reset
REQ-031 Assertion of i_reset_n=0 SHALL immediately force: state IDLE, o_note_ready=0, o_SPI_flag=0, o_SPI_note_status=0, o_SPI_voice_index=0, o_SPI_tuning_code=0, o_SPI_velocity=0, o_dropped=0, o_active_count=0.
REQ-032 Reset SHALL clear all table active bits, notes and tuning codes, and the steal pointer to 0.
REQ-033 o_note_ready SHALL rise on the first rising edge after i_reset_n deasserts.
REQ-034 Reset during SCAN or ISSUE SHALL abort the event with no o_SPI_flag and no table change surviving.

Configuration
REQ-035 Macro VOICE_STEAL_EN SHALL select full-table note-on behaviour.
REQ-036 Without VOICE_STEAL_EN: note-on with no retrigger and no free slot SHALL be dropped with o_dropped pulse, no flag.
REQ-037 With VOICE_STEAL_EN: such note-on SHALL target the slot at the round-robin steal pointer, issue as REQ-026, then increment the pointer modulo NUM_VOICES.

Verification (NUM_VOICES=16)
REQ-038 Reset release; note-on 60 vel 100 tuning 0x0001_0000 -> flag 17 edges later, index 0, status 1, velocity 100, count 1.
REQ-039 Then note-on 64, note-off 60 -> second issue index 1; off issue index 0, status 0, tuning 0x0001_0000, velocity 0, count 1.
REQ-040 Note-on 60 twice -> both issues index 0, count 1.
REQ-041 16 distinct note-ons then note-on 90 -> with VOICE_STEAL_EN flag index 0 and count 16; without, o_dropped pulse, no flag, count 16.
REQ-042 Note-off 72 never held, and note-on 72 vel 0 -> no flag, o_dropped pulse each, ready back to 1.
REQ-043 Reset asserted mid-SCAN -> no flag, all outputs 0, count 0; next note-on lands on index 0.
